// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard unit: shadow pipeline of in-flight producers (EX..WB) that
// picks per-operand bypass selects and raises a load-use stall.
module fwd_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int REG_W      = 3,
  parameter int SKIP_R0    = 0,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1),
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       advance,
  input  logic                       issue_valid,
  input  logic                       issue_regwrite,
  input  logic [REG_W-1:0]           issue_destreg,
  input  logic [SEL_W-1:0]           issue_rdy_stage,
  input  logic [NUM_SRC*REG_W-1:0]   src_reg,
  input  logic [NUM_SRC-1:0]         src_used,
  input  logic [NUM_STAGES-1:0]      flush_mask,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic                       stall,
  output logic [CNT_W-1:0]           stall_cycles
);

  logic [NUM_STAGES-1:0] v_q, v_d;
  logic [NUM_STAGES-1:0] rw_q, rw_d;
  logic [REG_W-1:0]      dest_q [NUM_STAGES];
  logic [REG_W-1:0]      dest_d [NUM_STAGES];
  logic [SEL_W-1:0]      rs_q   [NUM_STAGES];
  logic [SEL_W-1:0]      rs_d   [NUM_STAGES];
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_STAGES-1:0] ready;
  logic [NUM_STAGES-1:0] writer;
  logic [NUM_SRC-1:0]    blocked;

  // A ready stage beyond the last entry is never reached, so such a producer
  // never forwards and its dependants wait for the register file.
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_entry
      assign ready[gi]  = (int'(rs_q[gi]) <= gi);
      assign writer[gi] = v_q[gi] && rw_q[gi] &&
                          ((dest_q[gi] != '0) || (SKIP_R0 == 0));
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_W-1:0] src;
      logic [SEL_W-1:0] sel;
      logic             blk;

      assign src = src_reg[gi*REG_W +: REG_W];

      // Scan oldest to youngest so the youngest match has the final say.
      always_comb begin
        sel = '0;
        blk = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
          if (writer[i] && src_used[gi] && (dest_q[i] == src)) begin
            if (ready[i]) begin
              sel = SEL_W'(i + 1);
              blk = 1'b0;
            end else begin
              sel = '0;
              blk = 1'b1;
            end
          end
        end
      end

      assign fwd_sel[gi*SEL_W +: SEL_W] = sel;
      assign blocked[gi]                = blk;
    end
  endgenerate

  assign stall        = issue_valid && (|blocked);
  assign stall_cycles = cnt_q;

  always_comb begin
    v_d    = v_q;
    rw_d   = rw_q;
    dest_d = dest_q;
    rs_d   = rs_q;
    if (advance) begin
      for (int i = NUM_STAGES - 1; i >= 1; i--) begin
        v_d[i]    = v_q[i-1];
        rw_d[i]   = rw_q[i-1];
        dest_d[i] = dest_q[i-1];
        rs_d[i]   = rs_q[i-1];
      end
      v_d[0]    = issue_valid && !stall;
      rw_d[0]   = issue_regwrite;
      dest_d[0] = issue_destreg;
      rs_d[0]   = issue_rdy_stage;
    end
    // Flush wins over a same-edge issue into entry 0.
    v_d = v_d & ~flush_mask;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && advance && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      rw_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        dest_q[i] <= '0;
        rs_q[i]   <= '0;
      end
    end else begin
      v_q    <= v_d;
      rw_q   <= rw_d;
      cnt_q  <= cnt_d;
      dest_q <= dest_d;
      rs_q   <= rs_d;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: a default instance plus one with SKIP_R0=1, CNT_W=4
// driven from the same inputs.
module tb_fwd_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       advance, issue_valid, issue_regwrite;
  logic [2:0] issue_destreg;
  logic [1:0] issue_rdy_stage;
  logic [5:0] src_reg;
  logic [1:0] src_used;
  logic [2:0] flush_mask;
  logic [3:0] fwd_sel_a, fwd_sel_b;
  logic       stall_a, stall_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  fwd_scoreboard dut_a (
    .clk(clk), .rst_n(rst_n), .advance(advance), .issue_valid(issue_valid),
    .issue_regwrite(issue_regwrite), .issue_destreg(issue_destreg),
    .issue_rdy_stage(issue_rdy_stage), .src_reg(src_reg), .src_used(src_used),
    .flush_mask(flush_mask), .fwd_sel(fwd_sel_a), .stall(stall_a),
    .stall_cycles(cnt_a)
  );

  fwd_scoreboard #(.SKIP_R0(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .advance(advance), .issue_valid(issue_valid),
    .issue_regwrite(issue_regwrite), .issue_destreg(issue_destreg),
    .issue_rdy_stage(issue_rdy_stage), .src_reg(src_reg), .src_used(src_used),
    .flush_mask(flush_mask), .fwd_sel(fwd_sel_b), .stall(stall_b),
    .stall_cycles(cnt_b)
  );

  typedef struct {
    logic       adv, iv, irw;
    logic [2:0] dest;
    logic [1:0] rdy;
    logic [2:0] s0, s1;
    logic [1:0] used;
    logic [2:0] flush;
    logic [1:0] e_sel0, e_sel1;
    logic       e_stall;
    logic [1:0] b_sel0, b_sel1;
  } vec_t;

  typedef struct {
    logic [1:0]  s0, s1, b0, b1;
    logic        st;
    logic [15:0] ca;
    logic [3:0]  cb;
  } exp_t;

  vec_t vt[$];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_cnt_a = 0;
  int   m_cnt_b = 0;

  function automatic vec_t mk(input logic adv, iv, irw, input logic [2:0] dest,
                              input logic [1:0] rdy, input logic [2:0] s0, s1,
                              input logic [1:0] used, input logic [2:0] flush,
                              input logic [1:0] es0, es1, input logic est,
                              input logic [1:0] bs0, bs1);
    vec_t v;
    v.adv = adv; v.iv = iv; v.irw = irw; v.dest = dest; v.rdy = rdy;
    v.s0 = s0; v.s1 = s1; v.used = used; v.flush = flush;
    v.e_sel0 = es0; v.e_sel1 = es1; v.e_stall = est; v.b_sel0 = bs0; v.b_sel1 = bs1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    advance         = v.adv;
    issue_valid     = v.iv;
    issue_regwrite  = v.irw;
    issue_destreg   = v.dest;
    issue_rdy_stage = v.rdy;
    src_reg         = {v.s1, v.s0};
    src_used        = v.used;
    flush_mask      = v.flush;
  endtask

  task automatic set_in(input logic adv, iv, input logic [2:0] dest, input logic [1:0] rdy,
                        input logic [2:0] s0, s1, input logic [1:0] used);
    advance = adv; issue_valid = iv; issue_regwrite = 1'b1; issue_destreg = dest;
    issue_rdy_stage = rdy; src_reg = {s1, s0}; src_used = used; flush_mask = 3'b000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    set_in(1'b0, 1'b0, 3'd0, 2'd0, 3'd3, 3'd3, 2'b11);

    // Back-to-back ALU
    vt.push_back(mk(1,1,1,3,0, 5,6,2'b11,3'b000, 0,0,0, 0,0));
    vt.push_back(mk(1,1,0,0,0, 3,6,2'b01,3'b000, 1,0,0, 1,0));
    vt.push_back(mk(1,0,0,0,0, 3,6,2'b01,3'b000, 2,0,0, 2,0));
    vt.push_back(mk(1,0,0,0,0, 3,6,2'b01,3'b000, 3,0,0, 3,0));
    // Load-use
    vt.push_back(mk(1,1,1,2,1, 1,1,2'b00,3'b000, 0,0,0, 0,0));
    vt.push_back(mk(1,1,1,5,0, 2,7,2'b11,3'b000, 0,0,1, 0,0));
    vt.push_back(mk(1,1,1,5,0, 2,7,2'b11,3'b000, 2,0,0, 2,0));
    vt.push_back(mk(1,0,0,0,0, 5,2,2'b11,3'b000, 1,3,0, 1,3));
    vt.push_back(mk(1,0,0,0,0, 5,2,2'b00,3'b000, 0,0,0, 0,0));
    // Youngest wins
    vt.push_back(mk(1,1,1,4,0, 4,4,2'b00,3'b000, 0,0,0, 0,0));
    vt.push_back(mk(1,1,1,4,1, 4,1,2'b01,3'b000, 1,0,0, 1,0));
    vt.push_back(mk(1,1,1,6,0, 4,1,2'b01,3'b000, 0,0,1, 0,0));
    vt.push_back(mk(1,1,1,6,0, 4,1,2'b01,3'b000, 2,0,0, 2,0));
    // Freeze with a blocked dependant, then flush entry 0
    vt.push_back(mk(1,1,1,1,1, 4,1,2'b00,3'b000, 0,0,0, 0,0));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0,1,1,7,0, 1,6,2'b11,3'b000, 0,2,1, 0,2));
    vt.push_back(mk(0,1,1,7,0, 1,6,2'b11,3'b001, 0,2,1, 0,2));
    vt.push_back(mk(0,1,1,7,0, 1,6,2'b11,3'b000, 0,2,0, 0,2));
    // Issue and flush[0] on the same edge drops the issue
    vt.push_back(mk(1,1,1,3,0, 3,6,2'b00,3'b001, 0,0,0, 0,0));
    vt.push_back(mk(1,0,0,0,0, 3,6,2'b11,3'b000, 0,3,0, 0,3));
    // R0 producer and src_used
    vt.push_back(mk(1,1,1,0,0, 1,1,2'b00,3'b000, 0,0,0, 0,0));
    vt.push_back(mk(1,0,0,0,0, 0,0,2'b01,3'b000, 1,0,0, 0,0));
    vt.push_back(mk(1,0,0,0,0, 0,0,2'b00,3'b000, 0,0,0, 0,0));
    vt.push_back(mk(1,0,0,0,0, 0,0,2'b10,3'b000, 0,3,0, 0,0));
    // Never-ready producer: dependants stall until it retires
    vt.push_back(mk(1,1,1,5,3, 1,1,2'b00,3'b000, 0,0,0, 0,0));
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(1,1,1,1,0, 5,1,2'b01,3'b000, 0,0,1, 0,0));
    vt.push_back(mk(1,1,1,1,0, 5,1,2'b01,3'b000, 0,0,0, 0,0));

    @(negedge clk);
    check("reset_fwd_sel", {28'd0, fwd_sel_a}, 32'd0);
    check("reset_stall", {31'd0, stall_a}, 32'd0);
    check("reset_cnt", {16'd0, cnt_a}, 32'd0);
    $display("[TB] reset sel=%h stall=%b cnt=%0d", fwd_sel_a, stall_a, cnt_a);
    rst_n = 1'b1;

    foreach (vt[r]) begin
      drive(vt[r]);
      e.s0 = vt[r].e_sel0; e.s1 = vt[r].e_sel1; e.st = vt[r].e_stall;
      e.b0 = vt[r].b_sel0; e.b1 = vt[r].b_sel1;
      e.ca = 16'(m_cnt_a); e.cb = 4'(m_cnt_b);
      exp_q.push_back(e);
      #1;
      e = exp_q.pop_front();
      check($sformatf("row%0d_sel0", r), {30'd0, fwd_sel_a[1:0]}, {30'd0, e.s0});
      check($sformatf("row%0d_sel1", r), {30'd0, fwd_sel_a[3:2]}, {30'd0, e.s1});
      check($sformatf("row%0d_stall", r), {31'd0, stall_a}, {31'd0, e.st});
      check($sformatf("row%0d_cnt", r), {16'd0, cnt_a}, {16'd0, e.ca});
      check($sformatf("row%0d_b_sel0", r), {30'd0, fwd_sel_b[1:0]}, {30'd0, e.b0});
      check($sformatf("row%0d_b_sel1", r), {30'd0, fwd_sel_b[3:2]}, {30'd0, e.b1});
      check($sformatf("row%0d_b_stall", r), {31'd0, stall_b}, {31'd0, e.st});
      check($sformatf("row%0d_b_cnt", r), {28'd0, cnt_b}, {28'd0, e.cb});
      $display("[TB] row %0d sel=%h/%h stall=%b/%b cnt=%0d/%0d",
               r, fwd_sel_a, fwd_sel_b, stall_a, stall_b, cnt_a, cnt_b);
      if (vt[r].e_stall && vt[r].adv) begin
        m_cnt_a++;
        if (m_cnt_b < 15) m_cnt_b++;
      end
      @(negedge clk);
    end

    // Repeated load R2 depending on R2: stalls every other cycle, 20 stalls total
    set_in(1'b1, 1'b1, 3'd2, 2'd1, 3'd2, 3'd0, 2'b01);
    for (int j = 0; j < 40; j++) begin
      #1;
      check($sformatf("sat%0d_stall", j), {31'd0, stall_a}, (j % 2 == 1) ? 32'd1 : 32'd0);
      if (j % 2 == 1) begin
        m_cnt_a++;
        if (m_cnt_b < 15) m_cnt_b++;
      end
      @(negedge clk);
    end
    #1;
    check("sat_cnt_a", {16'd0, cnt_a}, 32'(m_cnt_a));
    check("sat_cnt_b", {28'd0, cnt_b}, 32'd15);
    $display("[TB] saturation cnt_a=%0d cnt_b=%0d", cnt_a, cnt_b);
    @(negedge clk);

    // Async reset in the middle of a stall
    set_in(1'b1, 1'b1, 3'd6, 2'd0, 3'd6, 3'd6, 2'b00);
    @(negedge clk);
    set_in(1'b1, 1'b1, 3'd2, 2'd1, 3'd6, 3'd6, 2'b00);
    @(negedge clk);
    set_in(1'b1, 1'b1, 3'd7, 2'd0, 3'd2, 3'd6, 2'b11);
    #1;
    check("pre_rst_stall", {31'd0, stall_a}, 32'd1);
    check("pre_rst_sel1", {30'd0, fwd_sel_a[3:2]}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("rst_stall", {31'd0, stall_a}, 32'd0);
    check("rst_fwd_sel", {28'd0, fwd_sel_a}, 32'd0);
    check("rst_cnt_a", {16'd0, cnt_a}, 32'd0);
    check("rst_cnt_b", {28'd0, cnt_b}, 32'd0);
    $display("[TB] async reset sel=%h stall=%b cnt=%0d", fwd_sel_a, stall_a, cnt_a);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b1, 1'b1, 3'd7, 2'd0, 3'd2, 3'd6, 2'b11);
    #1;
    check("post_rst_sel", {28'd0, fwd_sel_a}, 32'd0);
    check("post_rst_stall", {31'd0, stall_a}, 32'd0);
    @(negedge clk);
    set_in(1'b1, 1'b0, 3'd0, 2'd0, 3'd7, 3'd0, 2'b01);
    #1;
    check("post_rst_fwd", {30'd0, fwd_sel_a[1:0]}, 32'd1);
    $display("[TB] post reset sel=%h stall=%b", fwd_sel_a, stall_a);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipelined lc3b datapath.
- Keeps an internal shadow pipeline of in-flight producers (valid, regwrite, dest, ready stage) covering EX through the last bypassable stage.
- For every source operand in ID it returns a bypass-mux select naming the youngest ready producer, and raises a load-use stall when the youngest matching producer's data is not yet available.
- Sits between the ID/EX register and the operand bypass muxes.

Parameters:
- NUM_SRC, 2, number of source operands checked per cycle.
- NUM_STAGES, 3, bypassable stages tracked; entry 0 = EX, 1 = MEM, 2 = WB.
- REG_W, 3, register specifier width.
- SKIP_R0, 0, when 1 destination register 0 never matches; lc3b uses 0 because R0 is a real register.
- SEL_W, $clog2(NUM_STAGES+1), width of each bypass select field.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- advance  in  1  pipeline moves this cycle; 0 = global freeze, e.g. cache miss.
- issue_valid  in  1  ID holds a valid instruction.
- issue_regwrite  in  1  ID instruction writes a register.
- issue_destreg  in  REG_W  ID destination register.
- issue_rdy_stage  in  SEL_W  first entry index whose output carries the result (0 = ALU, 1 = load).
- src_reg  in  NUM_SRC*REG_W  ID source specifiers, operand k at [k*REG_W +: REG_W].
- src_used  in  NUM_SRC  operand k is actually read.
- flush_mask  in  NUM_STAGES  invalidate entry i at this edge.
- fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, i+1 = forward from entry i.
- stall  out  1  hold PC/IF/ID and insert a bubble into EX.
- stall_cycles  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset, asynchronous, any time including mid-stall:
  - all entry valid bits = 0, so fwd_sel = 0 and stall = 0.
  - stall_cycles = 0.
  - Takes effect immediately; the first edge after release behaves as an empty pipeline.
- Entry i holds: v, rw, dest, rs, where rs = ready stage.
- Entry i is ready when i >= rs.
- Entry i is a match for operand k when all of the following hold:
  - v and rw are set.
  - dest == src_reg[k].
  - src_used[k] is set.
  - dest != 0, or SKIP_R0 == 0.
- Combinational outputs, from registered state plus the ID inputs:
  - Youngest match wins: the lowest index i.
  - Youngest match ready -> fwd_sel[k] = i+1.
  - Youngest match not ready -> operand k is blocked and fwd_sel[k] = 0. Older ready entries are never used as a substitute.
  - No match -> fwd_sel[k] = 0.
  - stall = issue_valid & (any operand blocked).
- Sequential, at the rising edge:
  - advance = 1:
    - entry[i] <= entry[i-1] for i >= 1.
    - entry[0] <= issue fields if issue_valid & !stall; otherwise entry[0] becomes a bubble (v = 0).
    - The oldest entry retires.
  - advance = 0: all entries hold, and issue is ignored.
  - flush_mask is applied after the shift/hold. Any entry i with flush_mask[i] = 1 gets v = 0 at this edge.
  - Issue and flush_mask[0] in the same edge: the issued instruction is dropped.
  - stall_cycles increments when stall & advance, and saturates at all-ones (no wrap).
- Boundary conditions:
  - issue_rdy_stage >= NUM_STAGES: the entry is never ready, so dependants stall until it retires, then read the register file.
  - A source matching two entries always takes the younger.
  - A stalled load advances each cycle; once it reaches entry rs, stall drops in the same cycle and fwd_sel selects it.
  - Latency: an issued producer is visible in entry 0 exactly one advancing edge after issue.

Test Plan:
- Back-to-back ALU:
  - Issue ADD R3 (rdy 0), advance.
  - Next ID src_reg[0] = 3 -> fwd_sel[0] = 1, stall = 0.
  - One more advance with bubble -> fwd_sel[0] = 2.
- Load-use:
  - Issue LDR R2 (rdy 1), advance.
  - ID src 2 -> stall = 1, fwd_sel = 0.
  - Advance -> load in entry 1 -> stall = 0, fwd_sel = 2, stall_cycles = 1.
- Youngest wins:
  - Producers R4 (rdy 0) in entry 1 and R4 (rdy 1) in entry 0.
  - src 4 -> stall = 1; the older ready entry is not used.
- Freeze and flush:
  - advance = 0 for 5 cycles with a dependant in ID -> entries unchanged, stall_cycles unchanged.
  - Then flush_mask = 3'b001 -> entry 0 invalid, fwd_sel = 0.
- R0 and src_used:
  - With SKIP_R0 = 0, a producer R0 forwards (fwd_sel = 1).
  - Rerun with SKIP_R0 = 1 -> fwd_sel = 0.
  - src_used = 0 on a matching operand -> fwd_sel = 0, no stall.
- Async reset and saturation:
  - Assert rst_n low between edges during a stall -> stall and fwd_sel drop immediately.
  - With CNT_W = 4, force 20 stall cycles -> stall_cycles = 15.
